// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM arbiter slice.
// Holds the CPU word width, the RAM depth in words, the byte-enable width
// and the arbiter FSM state type. The load/store unit imports the same package.
package ram_arbiter_pkg;

  localparam int unsigned CPU_WIDTH = 32;
  localparam int unsigned RAM_DEPTH = 256;
  localparam int unsigned BE_W      = 4;

  localparam logic [BE_W-1:0] BE_FULL = '1;
  localparam logic [BE_W-1:0] BE_NONE = '0;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_WRITE,
    ARB_RESP
  } arb_state_t;

endpackage

// File: rtl/ram_arbiter_byte_merge.sv
// byte_merge: per-byte-lane selection between new write data and the word
// currently held in RAM, used to build read-modify-write store words.
// Ports:
//   be     - byte enables, lane k is taken from wdata when be[k]=1
//   wdata  - new store data, byte lanes aligned
//   rdata  - existing RAM word
//   merged - combined word
module byte_merge
  import ram_arbiter_pkg::*;
(
  input  logic [BE_W-1:0]      be,
  input  logic [CPU_WIDTH-1:0] wdata,
  input  logic [CPU_WIDTH-1:0] rdata,
  output logic [CPU_WIDTH-1:0] merged
);

  always_comb begin
    merged = rdata;
    for (int unsigned k = 0; k < BE_W; k++) begin
      if (be[k]) merged[8*k +: 8] = wdata[8*k +: 8];
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter and access sequencer in front of a
// single-port, word-only RAM. Port 0 is instruction fetch, port 1 is
// load/store. Byte-enabled stores become read-modify-write sequences.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   mN_req/we/addr/be/wdata   - requester N command, held until mN_ack
//   mN_rdata, mN_ack          - one-cycle completion pulse with read data
//   ram_valid_ctrl            - RAM access strobe
//   ram_we_ctrl               - 1: RAM drives ram_data, 0: RAM writes it
//   ram_addr                  - word-aligned byte address to the RAM
//   ram_data                  - shared bus, driven here only in WRITE
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned ADDR_LSB   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [CPU_WIDTH-1:0] m0_addr,
  input  logic [BE_W-1:0]      m0_be,
  input  logic [CPU_WIDTH-1:0] m0_wdata,
  output logic [CPU_WIDTH-1:0] m0_rdata,
  output logic                 m0_ack,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [CPU_WIDTH-1:0] m1_addr,
  input  logic [BE_W-1:0]      m1_be,
  input  logic [CPU_WIDTH-1:0] m1_wdata,
  output logic [CPU_WIDTH-1:0] m1_rdata,
  output logic                 m1_ack,
  output logic                 ram_valid_ctrl,
  output logic                 ram_we_ctrl,
  output logic [CPU_WIDTH-1:0] ram_addr,
  inout  logic [CPU_WIDTH-1:0] ram_data
);

  arb_state_t state, state_next;

  logic                 last_grant;
  logic                 grant;
  logic                 grant_next;
  logic                 lat_we;
  logic [BE_W-1:0]      lat_be;
  logic [CPU_WIDTH-1:0] lat_addr;
  logic [CPU_WIDTH-1:0] lat_wdata;
  logic [CPU_WIDTH-1:0] rbuf;
  logic [CPU_WIDTH-1:0] merged;
  logic [CPU_WIDTH-1:0] word_addr;
  logic [CPU_WIDTH-1:0] wr_word;
  logic                 drive_bus;
  logic                 valid_raw;

  byte_merge u_byte_merge (
    .be     (lat_be),
    .wdata  (lat_wdata),
    .rdata  (ram_data),
    .merged (merged)
  );

  assign word_addr = (lat_addr >> ADDR_LSB) << ADDR_LSB;
  // A full-word store never needs the read data; drive the latched data directly.
  assign wr_word   = (lat_be == BE_FULL) ? lat_wdata : rbuf;
  assign ram_data  = drive_bus ? wr_word : 'z;

  // Arbitration; on a tie last_grant=0 after reset lets port 1 win first.
  always_comb begin
    grant_next = last_grant;
    if (m0_req && m1_req)  grant_next = FIXED_PRIO ? 1'b1 : !last_grant;
    else if (m1_req)       grant_next = 1'b1;
    else if (m0_req)       grant_next = 1'b0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE:   if (m0_req || m1_req) state_next = ARB_ACCESS;
      ARB_ACCESS: state_next = (!lat_we || lat_be == BE_NONE) ? ARB_RESP : ARB_WRITE;
      ARB_WRITE:  state_next = ARB_RESP;
      ARB_RESP:   state_next = ARB_IDLE;
      default:    state_next = ARB_IDLE;
    endcase
  end

  // Grant bookkeeping, command latch and read buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b0;
      grant      <= 1'b0;
      lat_we     <= 1'b0;
      lat_be     <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rbuf       <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (m0_req || m1_req) begin
            grant      <= grant_next;
            last_grant <= grant_next;
            lat_we     <= grant_next ? m1_we    : m0_we;
            lat_be     <= grant_next ? m1_be    : m0_be;
            lat_addr   <= grant_next ? m1_addr  : m0_addr;
            lat_wdata  <= grant_next ? m1_wdata : m0_wdata;
          end
        end
        ARB_ACCESS: rbuf <= lat_we ? merged : ram_data;
        default: ;
      endcase
    end
  end

  // Output decode
  always_comb begin
    valid_raw   = 1'b0;
    ram_we_ctrl = 1'b0;
    ram_addr    = '0;
    drive_bus   = 1'b0;
    m0_ack      = 1'b0;
    m1_ack      = 1'b0;
    m0_rdata    = '0;
    m1_rdata    = '0;
    case (state)
      ARB_ACCESS: begin
        valid_raw   = 1'b1;
        ram_we_ctrl = 1'b1;
        ram_addr    = word_addr;
      end
      ARB_WRITE: begin
        valid_raw   = 1'b1;
        ram_addr    = word_addr;
        drive_bus   = 1'b1;
      end
      ARB_RESP: begin
        m0_ack = !grant;
        m1_ack = grant;
        if (!lat_we) begin
          if (grant) m1_rdata = rbuf;
          else       m0_rdata = rbuf;
        end
      end
      default: ;
    endcase
  end

  // Reset blocks the strobe immediately so an interrupted write never commits.
  assign ram_valid_ctrl = valid_raw && !rst;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- DUT A: round-robin ----------------
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [3:0]  m0_be = 0, m1_be = 0;
  logic [31:0] m0_rdata, m1_rdata, ram_addr;
  logic        m0_ack, m1_ack, ram_valid_ctrl, ram_we_ctrl;
  wire  [31:0] ram_data;

  ram_arbiter #(.FIXED_PRIO(1'b0), .ADDR_LSB(2)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_be(m0_be),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_be(m1_be),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .ram_valid_ctrl(ram_valid_ctrl), .ram_we_ctrl(ram_we_ctrl),
    .ram_addr(ram_addr), .ram_data(ram_data)
  );

  // RAM model for DUT A: reads drive the bus, writes commit at negedge.
  logic [31:0] mem [0:RAM_DEPTH-1];
  logic [7:0]  a_idx;
  logic        poke_en = 0;
  logic [7:0]  poke_idx = 0;
  logic [31:0] poke_val = 0;
  assign a_idx    = ram_addr[9:2];
  assign ram_data = (ram_valid_ctrl && ram_we_ctrl) ? mem[a_idx] : 'z;
  always @(negedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_val;
    else if (ram_valid_ctrl && !ram_we_ctrl) mem[a_idx] <= ram_data;
  end

  // ---------------- DUT B: fixed priority ----------------
  logic        p_m0_req = 0, p_m1_req = 0;
  logic [31:0] p_m0_addr = 0, p_m1_addr = 0;
  logic [31:0] p_m0_rdata, p_m1_rdata, p_ram_addr;
  logic        p_m0_ack, p_m1_ack, p_ram_valid_ctrl, p_ram_we_ctrl;
  wire  [31:0] p_ram_data;

  ram_arbiter #(.FIXED_PRIO(1'b1), .ADDR_LSB(2)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_req(p_m0_req), .m0_we(1'b0), .m0_addr(p_m0_addr), .m0_be(4'h0),
    .m0_wdata(32'h0), .m0_rdata(p_m0_rdata), .m0_ack(p_m0_ack),
    .m1_req(p_m1_req), .m1_we(1'b0), .m1_addr(p_m1_addr), .m1_be(4'h0),
    .m1_wdata(32'h0), .m1_rdata(p_m1_rdata), .m1_ack(p_m1_ack),
    .ram_valid_ctrl(p_ram_valid_ctrl), .ram_we_ctrl(p_ram_we_ctrl),
    .ram_addr(p_ram_addr), .ram_data(p_ram_data)
  );

  // Read-only pattern RAM: word = address ^ 0x5A5A0000.
  assign p_ram_data = (p_ram_valid_ctrl && p_ram_we_ctrl) ? (p_ram_addr ^ 32'h5A5A_0000) : 'z;

  // ---------------- helpers (stimulus only) ----------------
  task automatic poke(input int idx, input logic [31:0] v);
    @(posedge clk); #1;
    poke_en = 1; poke_idx = idx[7:0]; poke_val = v;
    @(negedge clk); #1;
    poke_en = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  // Issues one request on DUT A and reports latency, data and side observations.
  task automatic access(input bit port, input bit we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata,
                        output int cycles, output logic [31:0] rdata,
                        output bit other_ack, output bit wr_strobe, output bit ack_after);
    bit got;
    @(negedge clk);
    if (port) begin m1_req = 1; m1_we = we; m1_addr = addr; m1_be = be; m1_wdata = wdata; end
    else      begin m0_req = 1; m0_we = we; m0_addr = addr; m0_be = be; m0_wdata = wdata; end
    cycles = 0; rdata = '0; other_ack = 0; wr_strobe = 0; got = 0;
    while (!got && cycles < 10) begin
      @(posedge clk); #1;
      cycles++;
      if (ram_valid_ctrl && !ram_we_ctrl) wr_strobe = 1;
      if (port ? m0_ack : m1_ack) other_ack = 1;
      if (cycles == 1) begin
        // Scramble the command after grant; the latched copy must be used.
        if (port) begin m1_addr = 32'hFFFF_FFFC; m1_be = 4'hF; m1_wdata = 32'h0; end
        else      begin m0_addr = 32'hFFFF_FFFC; m0_be = 4'hF; m0_wdata = 32'h0; end
      end
      if (port ? m1_ack : m0_ack) begin
        got = 1;
        rdata = port ? m1_rdata : m0_rdata;
        if (port) m1_req = 0; else m0_req = 0;
      end
    end
    if (!got) begin
      cycles = 99;
      m0_req = 0; m1_req = 0;
    end
    @(posedge clk); #1;
    ack_after = port ? m1_ack : m0_ack;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (m0_ack !== 1'b0) begin n_fail++; $display("FAIL reset_m0_ack: got %b want 0", m0_ack); end
    n_checks++; if (m1_ack !== 1'b0) begin n_fail++; $display("FAIL reset_m1_ack: got %b want 0", m1_ack); end
    n_checks++; if (m0_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_m0_rdata: got %h want 0", m0_rdata); end
    n_checks++; if (m1_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_m1_rdata: got %h want 0", m1_rdata); end
    n_checks++; if (ram_valid_ctrl !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ram_valid_ctrl); end
    n_checks++; if (ram_we_ctrl !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", ram_we_ctrl); end
    n_checks++; if (ram_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", ram_addr); end
  endtask

  task automatic test_read();
    int cyc; logic [31:0] rd; bit oth, ws, aft;
    poke(4, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, cyc, rd, oth, ws, aft);
    n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL read_latency: got %0d want 2", cyc); end
    n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL read_data: got %h want deadbeef", rd); end
    n_checks++; if (oth !== 1'b0) begin n_fail++; $display("FAIL read_m0_ack: got %b want 0", oth); end
    n_checks++; if (ws !== 1'b0) begin n_fail++; $display("FAIL read_no_write: got %b want 0", ws); end
    n_checks++; if (aft !== 1'b0) begin n_fail++; $display("FAIL read_ack_pulse: got %b want 0", aft); end
  endtask

  task automatic test_partial_write();
    int cyc; logic [31:0] rd; bit oth, ws, aft;
    poke(8, 32'h1122_3344);
    access(1'b1, 1'b1, 32'h20, 4'b0001, 32'h0000_00AB, cyc, rd, oth, ws, aft);
    n_checks++; if (cyc != 3) begin n_fail++; $display("FAIL pw_latency: got %0d want 3", cyc); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL pw_rdata: got %h want 0", rd); end
    n_checks++; if (mem[8] !== 32'h1122_33AB) begin n_fail++; $display("FAIL pw_mem: got %h want 112233ab", mem[8]); end
    access(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, cyc, rd, oth, ws, aft);
    n_checks++; if (rd !== 32'h1122_33AB) begin n_fail++; $display("FAIL pw_readback: got %h want 112233ab", rd); end
    // Port 0, middle lanes, unaligned address bits ignored.
    poke(9, 32'hAABB_CCDD);
    access(1'b0, 1'b1, 32'h27, 4'b0110, 32'h0055_5500, cyc, rd, oth, ws, aft);
    n_checks++; if (cyc != 3) begin n_fail++; $display("FAIL pw0_latency: got %0d want 3", cyc); end
    n_checks++; if (ws !== 1'b1) begin n_fail++; $display("FAIL pw0_strobe: got %b want 1", ws); end
    n_checks++; if (mem[9] !== 32'hAA55_55DD) begin n_fail++; $display("FAIL pw0_mem: got %h want aa5555dd", mem[9]); end
    n_checks++; if (oth !== 1'b0) begin n_fail++; $display("FAIL pw0_m1_ack: got %b want 0", oth); end
    // 0x424 aliases word 9 in a 256-word RAM.
    access(1'b1, 1'b0, 32'h424, 4'h0, 32'h0, cyc, rd, oth, ws, aft);
    n_checks++; if (rd !== 32'hAA55_55DD) begin n_fail++; $display("FAIL alias_read: got %h want aa5555dd", rd); end
    // Full-word store.
    access(1'b1, 1'b1, 32'h28, 4'hF, 32'h0BAD_F00D, cyc, rd, oth, ws, aft);
    n_checks++; if (mem[10] !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL full_mem: got %h want 0badf00d", mem[10]); end
  endtask

  task automatic test_be_zero();
    int cyc; logic [31:0] rd; bit oth, ws, aft;
    poke(16, 32'h1234_5678);
    access(1'b1, 1'b1, 32'h40, 4'h0, 32'hFFFF_FFFF, cyc, rd, oth, ws, aft);
    n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL be0_latency: got %0d want 2", cyc); end
    n_checks++; if (ws !== 1'b0) begin n_fail++; $display("FAIL be0_no_write: got %b want 0", ws); end
    n_checks++; if (mem[16] !== 32'h1234_5678) begin n_fail++; $display("FAIL be0_mem: got %h want 12345678", mem[16]); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL be0_rdata: got %h want 0", rd); end
  endtask

  task automatic test_round_robin();
    int order[$]; int times[$]; logic [31:0] data[$];
    do_reset();
    m0_we = 0; m0_addr = 32'h10; m0_be = 0;
    m1_we = 0; m1_addr = 32'h20; m1_be = 0;
    m0_req = 1; m1_req = 1;
    for (int c = 1; c <= 40 && order.size() < 6; c++) begin
      @(posedge clk); #1;
      if (m0_ack) begin order.push_back(0); times.push_back(c); data.push_back(m0_rdata); end
      if (m1_ack) begin order.push_back(1); times.push_back(c); data.push_back(m1_rdata); end
    end
    m0_req = 0; m1_req = 0;
    repeat (4) @(posedge clk);
    n_checks++; if (order.size() != 6) begin n_fail++; $display("FAIL rr_count: got %0d want 6", order.size()); end
    if (order.size() == 6) begin
      n_checks++; if (times[0] != 2) begin n_fail++; $display("FAIL rr_first_time: got %0d want 2", times[0]); end
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (order[i] != ((i % 2 == 0) ? 1 : 0)) begin
          n_fail++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], (i % 2 == 0) ? 1 : 0);
        end
        n_checks++;
        if (data[i] !== ((i % 2 == 0) ? 32'h1122_33AB : 32'hDEAD_BEEF)) begin
          n_fail++; $display("FAIL rr_data[%0d]: got %h", i, data[i]);
        end
        if (i > 0) begin
          n_checks++;
          if (times[i] - times[i-1] != 3) begin
            n_fail++; $display("FAIL rr_spacing[%0d]: got %0d want 3", i, times[i] - times[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int cyc; logic [31:0] rd; bit oth, ws, aft;
    do_reset();
    poke(12, 32'h0);
    @(negedge clk);
    m1_req = 1; m1_we = 1; m1_addr = 32'h30; m1_be = 4'hF; m1_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    n_checks++; if (ram_we_ctrl !== 1'b1) begin n_fail++; $display("FAIL mw_access_we: got %b want 1", ram_we_ctrl); end
    @(posedge clk); #1;
    n_checks++; if (ram_we_ctrl !== 1'b0 || ram_addr !== 32'h30) begin
      n_fail++; $display("FAIL mw_write_phase: got we=%b addr=%h want we=0 addr=30", ram_we_ctrl, ram_addr);
    end
    rst = 1; m1_req = 0;
    #1;
    n_checks++; if (ram_valid_ctrl !== 1'b0) begin n_fail++; $display("FAIL mw_valid_gated: got %b want 0", ram_valid_ctrl); end
    @(posedge clk); #1;
    n_checks++; if (mem[12] !== 32'h0) begin n_fail++; $display("FAIL mw_mem: got %h want 0", mem[12]); end
    n_checks++; if (m1_ack !== 1'b0 || ram_valid_ctrl !== 1'b0 || ram_addr !== 32'h0) begin
      n_fail++; $display("FAIL mw_outputs: got ack=%b valid=%b addr=%h want 0", m1_ack, ram_valid_ctrl, ram_addr);
    end
    @(negedge clk);
    rst = 0;
    access(1'b1, 1'b0, 32'h30, 4'h0, 32'h0, cyc, rd, oth, ws, aft);
    n_checks++; if (cyc != 2 || rd !== 32'h0) begin
      n_fail++; $display("FAIL mw_after_read: got cyc=%0d data=%h want 2/0", cyc, rd);
    end
  endtask

  task automatic test_fixed_prio();
    int c0, c1, bad;
    c0 = 0; c1 = 0; bad = 0;
    do_reset();
    p_m0_addr = 32'h10; p_m1_addr = 32'h20;
    p_m0_req = 1; p_m1_req = 1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (p_m0_ack) c0++;
      if (p_m1_ack) begin
        c1++;
        if (p_m1_rdata !== 32'h5A5A_0020) bad++;
      end
      if (p_m0_rdata !== 32'h0) bad++;
    end
    p_m0_req = 0; p_m1_req = 0;
    repeat (4) @(posedge clk);
    n_checks++; if (c1 != 4) begin n_fail++; $display("FAIL fp_m1_grants: got %0d want 4", c1); end
    n_checks++; if (c0 != 0) begin n_fail++; $display("FAIL fp_m0_grants: got %0d want 0", c0); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL fp_rdata: got %0d bad samples want 0", bad); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read();
    test_partial_write();
    test_be_zero();
    test_round_robin();
    test_reset_mid_write();
    test_fixed_prio();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
